// File: rtl/wb_mem_reader_if.sv
// Wishbone classic read bus plus the valid/ready word stream of the memory reader.
// Signal suffixes are written from the reader's (master's) point of view.
interface wb_mem_reader_if #(
  parameter int AW = 32
);
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [31:0]   data_o;
  logic          data_valid_o;
  logic          data_ready_i;
  logic          data_last_o;

  modport master (
    output wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output data_o, data_valid_o, data_last_o,
    input  data_ready_i
  );

  modport slave (
    input  wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  data_o, data_valid_o, data_last_o,
    output data_ready_i
  );
endinterface

// File: rtl/wb_mem_reader.sv
// Wishbone B3 classic read master: reads len_i consecutive 32-bit words starting at
// base_adr_i, one bus transaction at a time, and streams each word out through a
// single-entry buffer on a valid/ready port.
module wb_mem_reader #(
  parameter int AW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    base_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  wb_mem_reader_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Timeout counter needs at least one bit even when the timeout is disabled.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [LEN_W-1:0] rem_q, rem_d;   // words left, including the one in flight
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;

  // Next-state logic for the read sequencer.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          adr_d   = base_adr_i & ~AW'(3);
          rem_d   = len_i;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = (len_i != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        // err wins over a simultaneous ack; the word is dropped.
        if (bus.wb_err_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus.wb_ack_i) begin
          buf_d   = bus.wb_dat_i;
          state_d = S_OUT;
        end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_OUT: begin
        if (bus.data_ready_i) begin
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            adr_d   = adr_q + AW'(4);
            rem_d   = rem_q - LEN_W'(1);
            tmo_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops the bus cycle and discards the held word at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them asynchronously.
  assign bus.wb_cyc_o     = (state_q == S_REQ);
  assign bus.wb_stb_o     = (state_q == S_REQ);
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_sel_o     = 4'hf;
  assign bus.wb_we_o      = 1'b0;
  assign bus.data_o       = buf_q;
  assign bus.data_valid_o = (state_q == S_OUT);
  assign bus.data_last_o  = (state_q == S_OUT) && (rem_q == LEN_W'(1));
  assign busy_o           = (state_q == S_REQ) || (state_q == S_OUT);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;

endmodule

// File: tb/tb_wb_mem_reader.sv
// Directed bench for wb_mem_reader: a table of block reads against a zero-wait
// combinational slave, plus hand sequences for DONE-cycle start and async reset.
module tb_wb_mem_reader;
  localparam int AW = 32, LEN_W = 16, TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [AW-1:0]    base  = '0;
  logic [LEN_W-1:0] len   = '0;
  logic             busy, done, err;
  logic             ack_en = 1'b1, err_en = 1'b0, stray = 1'b0, ready = 1'b1;
  logic [AW-1:0]    err_adr = '0;

  int checks = 0;
  int errors = 0;

  wb_mem_reader_if #(.AW(AW)) bus();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // Slave model: answers in the same cycle as the strobe; "stray" drives ack/err while idle.
  assign bus.wb_dat_i     = mem_word(bus.wb_adr_o);
  assign bus.wb_ack_i     = ack_en & (bus.wb_cyc_o | stray);
  assign bus.wb_err_i     = (bus.wb_cyc_o & err_en & (bus.wb_adr_o == err_adr)) | (stray & ~bus.wb_cyc_o);
  assign bus.data_ready_i = ready;

  wb_mem_reader #(.AW(AW), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .base_adr_i (base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .bus        (bus)
  );

  typedef struct {
    logic [AW-1:0]    base;
    logic [LEN_W-1:0] len;
    bit               ack;
    bit               erren;
    logic [AW-1:0]    eadr;
    int               stall_idx;
    int               stall_n;
    bit               stray;
    int               exp_words;
    bit               exp_err;
    int               exp_cyc;
    int               exp_req;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    int nw = 0, nreq = 0, ncyc = 0, stall = 0;
    logic prev_cyc = 1'b0;
    logic [31:0] held = '0;
    logic [AW-1:0] ea;
    bit got_done = 1'b0;
    @(negedge clk);
    ack_en = v.ack; err_en = v.erren; err_adr = v.eadr; stray = v.stray; ready = 1'b1;
    start = 1'b1; base = v.base; len = v.len;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", err, 0);
    if (v.len == 0) check("len0_done_next", done, 1);
    else check("cyc_after_start", bus.wb_cyc_o, 1);
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.wb_cyc_o) begin
        ncyc++;
        check("stb_eq_cyc", bus.wb_stb_o, 1);
        if (!prev_cyc) begin
          ea = v.base + AW'(4 * nreq);
          check("adr", bus.wb_adr_o, ea);
          nreq++;
        end
      end
      prev_cyc = bus.wb_cyc_o;
      if (bus.data_valid_o) begin
        if (nw == v.stall_idx && stall < v.stall_n) begin
          if (stall > 0) check("data_held", bus.data_o, held);
          check("no_cyc_while_held", bus.wb_cyc_o, 0);
          held = bus.data_o;
          stall++;
          ready = 1'b0;
        end else begin
          ready = 1'b1;
          ea = v.base + AW'(4 * nw);
          check("data", bus.data_o, mem_word(ea));
          check("last", bus.data_last_o, (nw == int'(v.len) - 1));
          nw++;
        end
      end else begin
        ready = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        check("err_at_done", err, v.exp_err);
        check("busy_at_done", busy, 0);
      end
    end
    check("done_seen", got_done, 1);
    check("nwords", nw, v.exp_words);
    check("ncyc", ncyc, v.exp_cyc);
    check("nreq", nreq, v.exp_req);
    @(negedge clk);
    check("done_single", done, 0);
    check("idle_cyc", bus.wb_cyc_o, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    //           base          len  ack erren eadr        sidx sn stray wds err cyc req
    vecs[0] = '{32'h0000_1000, 4,  1,  0, 32'h0,         -1, 0, 0,    4,  0,  4,  4};
    vecs[1] = '{32'h0000_1000, 4,  1,  0, 32'h0,          1, 5, 1,    4,  0,  4,  4};
    vecs[2] = '{32'h0000_1000, 0,  1,  0, 32'h0,         -1, 0, 0,    0,  0,  0,  0};
    vecs[3] = '{32'h0000_2000, 3,  1,  1, 32'h0000_2004, -1, 0, 0,    1,  1,  2,  2};
    vecs[4] = '{32'h0000_3000, 2,  0,  0, 32'h0,         -1, 0, 0,    0,  1,  8,  1};
    vecs[5] = '{32'hffff_fffc, 2,  1,  0, 32'h0,         -1, 0, 0,    2,  0,  2,  2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_adr", bus.wb_adr_o, 0);
    check("rst_we", bus.wb_we_o, 0);
    check("rst_sel", bus.wb_sel_o, 4'hf);
    check("rst_valid", bus.data_valid_o, 0);
    check("rst_last", bus.data_last_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // start during the DONE cycle is ignored
    @(negedge clk);
    ack_en = 1'b1; err_en = 1'b0; stray = 1'b0; ready = 1'b1;
    start = 1'b1; base = 32'h5000; len = 0;
    @(negedge clk);
    check("done_cycle", done, 1);
    len = 1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_cyc", bus.wb_cyc_o, 0);
    check("start_in_done_busy", busy, 0);

    // Asynchronous reset during REQ
    @(negedge clk);
    ack_en = 1'b0;
    start = 1'b1; base = 32'h6000; len = 1;
    @(negedge clk);
    start = 1'b0;
    check("req_before_rst", bus.wb_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", bus.wb_cyc_o, 0);
    check("async_rst_stb", bus.wb_stb_o, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", bus.data_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run('{32'h0000_4000, 1, 1, 0, 32'h0, -1, 0, 0, 1, 0, 1, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
